alu_op_sequencer: RTL

- Execute-phase sequencer in the multicycle control unit. Encodes the decoded instruction (opcode/funct) into the 4-bit ALUOp command stream consumed by the ALU control decoder.
- Issues one or two command cycles, waits for the registered decode and the ALU to settle, then consumes the decoder's returned branch signals (uc_control/uc_op) together with the ALU flags to resolve branches.
- Reports done, branch_taken and error flags to the main FSM.

---
 rtl/alu_op_sequencer_if.sv | 34 +++
 rtl/alu_op_sequencer.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/alu_op_sequencer_if.sv
// Command/flag bundle between the execute sequencer, the main FSM and the ALU control decoder.
// Pure wiring, so it adds no latency.
// No backpressure: start is level-sampled while idle, and the decoder response is sampled after a fixed settle time.
interface alu_op_sequencer_if #(
  parameter int OP_W = 4
);
  logic            start;
  logic [5:0]      opcode;
  logic [5:0]      funct;
  logic            zero;
  logic            lt;
  logic            gt;
  logic            uc_control;
  logic [1:0]      uc_op;
  logic [OP_W-1:0] alu_op;
  logic            alu_op_valid;
  logic            busy;
  logic            done;
  logic            branch_taken;
  logic            illegal;
  logic            protocol_err;

  // Main FSM / datapath side: drives the instruction and the flags, and observes the results.
  modport master (
    output start, opcode, funct, zero, lt, gt, uc_control, uc_op,
    input  alu_op, alu_op_valid, busy, done, branch_taken, illegal, protocol_err
  );

  // Sequencer side.
  modport slave (
    input  start, opcode, funct, zero, lt, gt, uc_control, uc_op,
    output alu_op, alu_op_valid, busy, done, branch_taken, illegal, protocol_err
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// Turns the latched opcode/funct into one or two ALUOp command cycles, then resolves the branch from the decoder response.
// Latency: done arrives 2+SETTLE_CYCLES cycles after the start cycle for single-issue ops, or 3+SETTLE_CYCLES for two-issue ops.
// No backpressure: start is ignored while busy, and a new start is accepted in the DONE cycle.
module alu_op_sequencer #(
  parameter int OP_W          = 4,
  parameter int SETTLE_CYCLES = 1
) (
  input logic               clk,
  input logic               reset,
  alu_op_sequencer_if.slave bus
);

  localparam logic [OP_W-1:0] OP_NOP  = OP_W'(4'h0);
  localparam logic [OP_W-1:0] OP_ADD  = OP_W'(4'h1);
  localparam logic [OP_W-1:0] OP_SUB  = OP_W'(4'h2);
  localparam logic [OP_W-1:0] OP_AND  = OP_W'(4'h3);
  localparam logic [OP_W-1:0] OP_SL1  = OP_W'(4'h5);
  localparam logic [OP_W-1:0] OP_SL2  = OP_W'(4'h6);
  localparam logic [OP_W-1:0] OP_SR   = OP_W'(4'h7);
  localparam logic [OP_W-1:0] OP_SRA1 = OP_W'(4'h8);
  localparam logic [OP_W-1:0] OP_SRA2 = OP_W'(4'h9);
  localparam logic [OP_W-1:0] OP_SLTI = OP_W'(4'hA);
  localparam logic [OP_W-1:0] OP_BEQ  = OP_W'(4'hB);
  localparam logic [OP_W-1:0] OP_BNE  = OP_W'(4'hC);
  localparam logic [OP_W-1:0] OP_BLE  = OP_W'(4'hD);
  localparam logic [OP_W-1:0] OP_BGT  = OP_W'(4'hE);
  localparam logic [OP_W-1:0] OP_LUI  = OP_W'(4'hF);

  // The counter holds the remaining SETTLE cycles minus one, so a value of 0 means this is the last one.
  localparam logic [2:0] SETTLE_LOAD = 3'(SETTLE_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ISSUE1 = 3'd1,
    S_ISSUE2 = 3'd2,
    S_SETTLE = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [5:0] opcode_q, opcode_d;
  logic [5:0] funct_q, funct_d;
  logic       taken_q, taken_d;
  logic       illegal_q, illegal_d;
  logic       perr_q, perr_d;

  logic [OP_W-1:0] cmd1, cmd2;
  logic            two_step;
  logic            dec_illegal;
  logic            is_branch;
  logic [1:0]      exp_uc_op;
  logic            br_cond;
  logic            resp_err;

  // Decode the latched instruction into its command steps.
  always_comb begin
    cmd1        = OP_NOP;
    cmd2        = OP_NOP;
    two_step    = 1'b0;
    dec_illegal = 1'b0;
    case (opcode_q)
      6'h00: begin
        case (funct_q)
          6'h20: cmd1 = OP_ADD;
          6'h22: cmd1 = OP_SUB;
          6'h24: cmd1 = OP_AND;
          6'h00, 6'h04: begin
            cmd1     = OP_SL1;
            cmd2     = OP_SL2;
            two_step = 1'b1;
          end
          6'h02: cmd1 = OP_SR;
          6'h03, 6'h07: begin
            cmd1     = OP_SRA1;
            cmd2     = OP_SRA2;
            two_step = 1'b1;
          end
          default: dec_illegal = 1'b1;
        endcase
      end
      6'h08, 6'h09, 6'h23, 6'h2B: cmd1 = OP_ADD;
      6'h0A:   cmd1 = OP_SLTI;
      6'h0F:   cmd1 = OP_LUI;
      6'h04:   cmd1 = OP_BEQ;
      6'h05:   cmd1 = OP_BNE;
      6'h06:   cmd1 = OP_BLE;
      6'h07:   cmd1 = OP_BGT;
      default: dec_illegal = 1'b1;
    endcase
    // The branch opcodes 0x04..0x07 map directly onto uc_op 00..11.
    is_branch = (opcode_q[5:2] == 4'b0001);
    exp_uc_op = opcode_q[1:0];
  end

  // Resolve the branch from the decoder-returned kind, and check the decoder answer against what was issued.
  always_comb begin
    case (bus.uc_op)
      2'b00:   br_cond = bus.zero;
      2'b01:   br_cond = ~bus.zero;
      2'b10:   br_cond = bus.zero | bus.lt;
      default: br_cond = bus.gt;
    endcase
    if (is_branch) begin
      resp_err = ~bus.uc_control | (bus.uc_op != exp_uc_op);
    end else begin
      resp_err = bus.uc_control;
    end
  end

  // Compute the next state, the settle countdown, the instruction latch and the results registered into DONE.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    opcode_d  = opcode_q;
    funct_d   = funct_q;
    taken_d   = 1'b0;
    illegal_d = 1'b0;
    perr_d    = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          opcode_d = bus.opcode;
          funct_d  = bus.funct;
          state_d  = S_ISSUE1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE1: begin
        if (two_step) begin
          state_d = S_ISSUE2;
        end else begin
          state_d = S_SETTLE;
          cnt_d   = SETTLE_LOAD;
        end
      end
      S_ISSUE2: begin
        state_d = S_SETTLE;
        cnt_d   = SETTLE_LOAD;
      end
      S_SETTLE: begin
        if (cnt_q == 3'd0) begin
          state_d   = S_DONE;
          illegal_d = dec_illegal;
          perr_d    = resp_err;
          taken_d   = is_branch & ~resp_err & br_cond;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, counter, instruction latch and result registers; a synchronous reset clears all of them.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= 3'd0;
      opcode_q  <= 6'd0;
      funct_q   <= 6'd0;
      taken_q   <= 1'b0;
      illegal_q <= 1'b0;
      perr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      opcode_q  <= opcode_d;
      funct_q   <= funct_d;
      taken_q   <= taken_d;
      illegal_q <= illegal_d;
      perr_q    <= perr_d;
    end
  end

  // Drive the command bus and the status flags from the current state.
  always_comb begin
    bus.alu_op       = OP_NOP;
    bus.alu_op_valid = 1'b0;
    if (state_q == S_ISSUE1) begin
      bus.alu_op       = cmd1;
      bus.alu_op_valid = 1'b1;
    end else if (state_q == S_ISSUE2) begin
      bus.alu_op       = cmd2;
      bus.alu_op_valid = 1'b1;
    end
    bus.busy         = (state_q == S_ISSUE1) || (state_q == S_ISSUE2) || (state_q == S_SETTLE);
    bus.done         = (state_q == S_DONE);
    bus.branch_taken = (state_q == S_DONE) & taken_q;
    bus.illegal      = (state_q == S_DONE) & illegal_q;
    bus.protocol_err = (state_q == S_DONE) & perr_q;
  end

endmodule
